// File: rtl/urv_defs.sv
`default_nettype none
//==============================================================================
// Package : urv_defs
// Brief   : Shared result-source codes, load funct3 codes and writeback states.
// Rev     : 1.0
//==============================================================================
package urv_defs;

   localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
   localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
   localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'd0,
      WB_WAIT_MEM = 2'd1,
      WB_HELD     = 2'd2
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/urv_load_align.sv
`default_nettype none
//==============================================================================
// Module : urv_load_align
// Brief  : Picks the addressed byte/halfword of load data and extends it.
// Rev    : 1.0
//==============================================================================
module urv_load_align
   import urv_defs::*;
(
   input  logic [2:0]  i_fun,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte  = i_data[7:0];
      w_half  = i_addr[1] ? i_data[31:16] : i_data[15:0];
      o_value = i_data;

      case (i_addr)
         2'd1:    w_byte = i_data[15:8];
         2'd2:    w_byte = i_data[23:16];
         2'd3:    w_byte = i_data[31:24];
         default: w_byte = i_data[7:0];
      endcase

      // LW and any unlisted funct3 pass the word through untouched.
      case (i_fun)
         LDST_B:  o_value = {{24{w_byte[7]}}, w_byte};
         LDST_BU: o_value = {24'h0, w_byte};
         LDST_H:  o_value = {{16{w_half[15]}}, w_half};
         LDST_HU: o_value = {16'h0, w_half};
         default: o_value = i_data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/urv_writeback.sv
`default_nettype none
//==============================================================================
// Module : urv_writeback
// Brief  : Final stage: result select, load completion handshake, single
//          register-file write per instruction and registered bypass.
// Rev    : 1.0
//==============================================================================
module urv_writeback
   import urv_defs::*;
#(
   parameter bit g_with_hw_mul  = 1'b1,
   parameter bit g_with_shifter = 1'b1
)
(
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        w_stall_i,
   output logic        w_stall_req_o,

   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic        x_valid_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [1:0]  x_rd_source_i,
   input  logic [31:0] x_shifter_rd_value_i,
   input  logic [31:0] x_multiply_rd_value_i,

   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,

   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,

   output logic [4:0]  x_bypass_rd_o,
   output logic [31:0] x_bypass_value_o,
   output logic        x_bypass_valid_o,
   output logic        w_load_hazard_o
);

   wb_state_t   r_state;
   logic        r_written;
   logic [31:0] r_load_data;
   logic [4:0]  r_byp_rd;
   logic [31:0] r_byp_value;
   logic        r_byp_valid;

   logic [31:0] w_mul_value;
   logic [31:0] w_shift_value;
   logic [31:0] w_src_value;
   logic [31:0] w_aligned;
   logic        w_is_mem;
   logic        w_done;
   logic        w_mem_ok;
   logic        w_load_live;
   logic        w_unused_addr;

   assign w_unused_addr = ^x_dm_addr_i[31:2];

   generate
      if (g_with_hw_mul) begin : g_mul
         assign w_mul_value = x_multiply_rd_value_i;
      end else begin : g_no_mul
         logic w_unused_mul;
         assign w_unused_mul = ^x_multiply_rd_value_i;
         assign w_mul_value  = 32'h0;
      end

      if (g_with_shifter) begin : g_shift
         assign w_shift_value = x_shifter_rd_value_i;
      end else begin : g_no_shift
         logic w_unused_shift;
         assign w_unused_shift = ^x_shifter_rd_value_i;
         assign w_shift_value  = 32'h0;
      end
   endgenerate

   always_comb begin
      w_src_value = x_rd_value_i;
      case (x_rd_source_i)
         RD_SOURCE_SHIFTER:  w_src_value = w_shift_value;
         RD_SOURCE_MULTIPLY: w_src_value = w_mul_value;
         default:            w_src_value = x_rd_value_i;
      endcase
   end

   urv_load_align u_align (
      .i_fun   (x_fun_i),
      .i_addr  (x_dm_addr_i[1:0]),
      .i_data  (dm_data_l_i),
      .o_value (w_aligned)
   );

   // Only the strobe matching the access kind completes it; once HELD the
   // result is already latched and further strobes are irrelevant.
   assign w_is_mem    = x_load_i | x_store_i;
   assign w_done      = (x_load_i & dm_load_done_i) | (x_store_i & dm_store_done_i);
   assign w_mem_ok    = ~w_is_mem | (r_state == WB_HELD) | w_done;
   assign w_load_live = x_load_i & dm_load_done_i & (r_state != WB_HELD);

   assign w_stall_req_o   = x_valid_i & w_is_mem & ~w_mem_ok;
   assign w_load_hazard_o = x_valid_i & x_load_i & ~w_mem_ok;

   assign rf_rd_o       = x_rd_i;
   assign rf_rd_write_o = x_valid_i & x_rd_write_i & (x_rd_i != 5'd0) & w_mem_ok & ~r_written;
   assign rf_rd_value_o = x_load_i ? (w_load_live ? w_aligned : r_load_data) : w_src_value;

   assign x_bypass_rd_o    = r_byp_rd;
   assign x_bypass_value_o = r_byp_value;
   assign x_bypass_valid_o = r_byp_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= WB_IDLE;
         r_written   <= 1'b0;
         r_load_data <= 32'h0;
         r_byp_rd    <= 5'd0;
         r_byp_value <= 32'h0;
         r_byp_valid <= 1'b0;
      end else begin
         if (rf_rd_write_o) begin
            r_byp_rd    <= x_rd_i;
            r_byp_value <= rf_rd_value_o;
            r_byp_valid <= 1'b1;
         end

         // Suppresses repeat writes while the instruction sits under stall.
         if (!w_stall_i) begin
            r_written <= 1'b0;
         end else if (rf_rd_write_o) begin
            r_written <= 1'b1;
         end

         if (x_valid_i && w_load_live) begin
            r_load_data <= w_aligned;
         end

         case (r_state)
            WB_HELD: begin
               if (!w_stall_i) begin
                  r_state <= WB_IDLE;
               end
            end
            default: begin
               if (x_valid_i && w_is_mem) begin
                  if (w_done) begin
                     r_state <= w_stall_i ? WB_HELD : WB_IDLE;
                  end else begin
                     r_state <= WB_WAIT_MEM;
                  end
               end else begin
                  r_state <= WB_IDLE;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_urv_writeback.sv
`default_nettype none
//==============================================================================
// Module : tb_urv_writeback
// Brief  : Self-checking bench for urv_writeback.
// Rev    : 1.0
//==============================================================================
module tb_urv_writeback;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        w_stall_i;
   logic        w_stall_req_o;
   logic [2:0]  x_fun_i;
   logic        x_load_i;
   logic        x_store_i;
   logic        x_valid_i;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i;
   logic        x_rd_write_i;
   logic [31:0] x_dm_addr_i;
   logic [1:0]  x_rd_source_i;
   logic [31:0] x_shifter_rd_value_i;
   logic [31:0] x_multiply_rd_value_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        dm_store_done_i;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_write_o;
   logic [4:0]  x_bypass_rd_o;
   logic [31:0] x_bypass_value_o;
   logic        x_bypass_valid_o;
   logic        w_load_hazard_o;

   urv_writeback #(
      .g_with_hw_mul  (1'b1),
      .g_with_shifter (1'b1)
   ) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .w_stall_i             (w_stall_i),
      .w_stall_req_o         (w_stall_req_o),
      .x_fun_i               (x_fun_i),
      .x_load_i              (x_load_i),
      .x_store_i             (x_store_i),
      .x_valid_i             (x_valid_i),
      .x_rd_i                (x_rd_i),
      .x_rd_value_i          (x_rd_value_i),
      .x_rd_write_i          (x_rd_write_i),
      .x_dm_addr_i           (x_dm_addr_i),
      .x_rd_source_i         (x_rd_source_i),
      .x_shifter_rd_value_i  (x_shifter_rd_value_i),
      .x_multiply_rd_value_i (x_multiply_rd_value_i),
      .dm_data_l_i           (dm_data_l_i),
      .dm_load_done_i        (dm_load_done_i),
      .dm_store_done_i       (dm_store_done_i),
      .rf_rd_o               (rf_rd_o),
      .rf_rd_value_o         (rf_rd_value_o),
      .rf_rd_write_o         (rf_rd_write_o),
      .x_bypass_rd_o         (x_bypass_rd_o),
      .x_bypass_value_o      (x_bypass_value_o),
      .x_bypass_valid_o      (x_bypass_valid_o),
      .w_load_hazard_o       (w_load_hazard_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  src;
      logic [4:0]  rd;
      logic        wr;
      logic        ld;
      logic [2:0]  fun;
      logic [1:0]  addr;
      logic [31:0] alu;
      logic [31:0] sh;
      logic [31:0] mul;
      logic [31:0] data;
      logic        exp_we;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs [14];

   int total = 0;
   int bad   = 0;

   // Reference state: expected bypass entry plus per-instruction progress.
   logic [4:0]  m_rd;
   logic [31:0] m_val;
   logic        m_valid;
   logic        m_mem_done;
   logic        m_written;
   logic [31:0] m_saved;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_bypass(input string tag);
      chk({tag, "_byp_rd"},    {27'd0, x_bypass_rd_o}, {27'd0, m_rd});
      chk({tag, "_byp_val"},   x_bypass_value_o, m_val);
      chk({tag, "_byp_valid"}, {31'd0, x_bypass_valid_o}, {31'd0, m_valid});
   endtask

   task automatic idle_inputs();
      w_stall_i             = 1'b0;
      x_fun_i               = 3'd0;
      x_load_i              = 1'b0;
      x_store_i             = 1'b0;
      x_valid_i             = 1'b0;
      x_rd_i                = 5'd0;
      x_rd_value_i          = 32'h0;
      x_rd_write_i          = 1'b0;
      x_dm_addr_i           = 32'h0;
      x_rd_source_i         = 2'd0;
      x_shifter_rd_value_i  = 32'h0;
      x_multiply_rd_value_i = 32'h0;
      dm_data_l_i           = 32'h0;
      dm_load_done_i        = 1'b0;
      dm_store_done_i       = 1'b0;
   endtask

   function automatic logic [31:0] ref_align(input logic [2:0] fun, input logic [1:0] addr,
                                             input logic [31:0] data);
      logic [31:0] b;
      logic [31:0] h;
      b = (data >> (8 * addr)) % 256;
      h = (data >> (16 * addr[1])) % 65536;
      case (fun)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return data;
      endcase
   endfunction

   // Load with done three cycles late while the pipeline honours the stall.
   task automatic run_delayed(input logic [2:0] fun, input logic [31:0] expv, input string tag);
      int writes;
      writes = 0;
      @(negedge clk_i);
      x_valid_i = 1'b1; x_load_i = 1'b1; x_store_i = 1'b0; x_fun_i = fun;
      x_dm_addr_i = 32'h0000_2003; x_rd_i = 5'd20; x_rd_write_i = 1'b1;
      x_rd_source_i = 2'd0; x_rd_value_i = 32'h5A5A_5A5A;
      dm_load_done_i = 1'b0; dm_store_done_i = 1'b0; w_stall_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk_i);
         dm_data_l_i = $urandom();
         #4;
         chk({tag, "_wait_stall"}, {31'd0, w_stall_req_o}, 32'd1);
         chk({tag, "_wait_hazard"}, {31'd0, w_load_hazard_o}, 32'd1);
         if (rf_rd_write_o) writes++;
      end
      @(negedge clk_i);
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h80FF_FFFF; w_stall_i = 1'b0;
      #4;
      chk({tag, "_done_stall"}, {31'd0, w_stall_req_o}, 32'd0);
      if (rf_rd_write_o) writes++;
      chk({tag, "_value"}, rf_rd_value_o, expv);
      chk({tag, "_writes"}, writes, 32'd1);
      @(posedge clk_i); #1;
      m_rd = 5'd20; m_val = expv; m_valid = 1'b1;
      chk_bypass(tag);
      @(negedge clk_i);
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   logic [1:0]  r_kind;
   logic        r_ld;
   logic        r_st;
   logic        r_wr;
   logic [1:0]  r_src;
   logic [4:0]  r_rd;
   logic [2:0]  r_fun;
   logic [31:0] r_addr;
   logic [31:0] r_alu;
   logic [31:0] r_sh;
   logic [31:0] r_mul;
   int          r_delay;
   logic        r_retired;
   logic        e_done;
   logic        e_ok;
   logic        e_stall;
   logic        e_we;
   logic [31:0] e_val;
   int          writes;

   initial begin
      idle_inputs();
      m_rd = 5'd0; m_val = 32'h0; m_valid = 1'b0;
      m_mem_done = 1'b0; m_written = 1'b0; m_saved = 32'h0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_stall_req", {31'd0, w_stall_req_o}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_rd_write_o}, 32'd0);
      chk("rst_hazard", {31'd0, w_load_hazard_o}, 32'd0);
      chk_bypass("rst");
      @(negedge clk_i);
      rst_i = 1'b0;

      // ---------------- single-cycle vector table ----------------
      //            src   rd     wr    ld    fun   addr  alu            sh             mul            data           we    val
      vecs[0]  = '{2'd0, 5'd5,  1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'h1111_1111, 32'h2222_2222, 32'h0,         1'b1, 32'h0000_1234};
      vecs[1]  = '{2'd1, 5'd7,  1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0001, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0,         1'b1, 32'hDEAD_BEEF};
      vecs[2]  = '{2'd2, 5'd8,  1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0002, 32'h1111_1111, 32'h0BAD_F00D, 32'h0,         1'b1, 32'h0BAD_F00D};
      vecs[3]  = '{2'd3, 5'd9,  1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_0003, 32'h1111_1111, 32'h2222_2222, 32'h0,         1'b1, 32'hCAFE_0003};
      vecs[4]  = '{2'd0, 5'd10, 1'b1, 1'b1, 3'd0, 2'd3, 32'h0,         32'h0,         32'h0,         32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80};
      vecs[5]  = '{2'd0, 5'd11, 1'b1, 1'b1, 3'd4, 2'd3, 32'h0,         32'h0,         32'h0,         32'h80FF_FFFF, 1'b1, 32'h0000_0080};
      vecs[6]  = '{2'd0, 5'd12, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0,         32'h0,         32'h0,         32'h8001_0000, 1'b1, 32'hFFFF_8001};
      vecs[7]  = '{2'd0, 5'd13, 1'b1, 1'b1, 3'd5, 2'd2, 32'h0,         32'h0,         32'h0,         32'h8001_0000, 1'b1, 32'h0000_8001};
      vecs[8]  = '{2'd0, 5'd14, 1'b1, 1'b1, 3'd0, 2'd1, 32'h0,         32'h0,         32'h0,         32'h0000_7F00, 1'b1, 32'h0000_007F};
      vecs[9]  = '{2'd0, 5'd15, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0,         32'h0,         32'h0,         32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF};
      vecs[10] = '{2'd0, 5'd16, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0,         32'h0,         32'h0,         32'h1234_5678, 1'b1, 32'h1234_5678};
      vecs[11] = '{2'd0, 5'd0,  1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_5555, 32'h0,         32'h0,         32'h0,         1'b0, 32'h0};
      vecs[12] = '{2'd0, 5'd17, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0000_6666, 32'h0,         32'h0,         32'h0,         1'b0, 32'h0};
      vecs[13] = '{2'd0, 5'd18, 1'b1, 1'b1, 3'd1, 2'd0, 32'h0,         32'h0,         32'h0,         32'h1234_FFFE, 1'b1, 32'hFFFF_FFFE};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk_i);
         x_valid_i = 1'b1; x_store_i = 1'b0; w_stall_i = 1'b0;
         x_rd_source_i = vecs[i].src; x_rd_i = vecs[i].rd; x_rd_write_i = vecs[i].wr;
         x_load_i = vecs[i].ld; x_fun_i = vecs[i].fun;
         x_dm_addr_i = ($urandom() & 32'hFFFF_FFFC) | {30'd0, vecs[i].addr};
         x_rd_value_i = vecs[i].alu; x_shifter_rd_value_i = vecs[i].sh;
         x_multiply_rd_value_i = vecs[i].mul;
         dm_data_l_i = vecs[i].data; dm_load_done_i = vecs[i].ld; dm_store_done_i = 1'b0;
         #4;
         chk($sformatf("vec%0d_we", i), {31'd0, rf_rd_write_o}, {31'd0, vecs[i].exp_we});
         chk($sformatf("vec%0d_stall", i), {31'd0, w_stall_req_o}, 32'd0);
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_val", i), rf_rd_value_o, vecs[i].exp_val);
            chk($sformatf("vec%0d_rd", i), {27'd0, rf_rd_o}, {27'd0, vecs[i].rd});
         end
         @(posedge clk_i); #1;
         if (vecs[i].exp_we) begin
            m_rd = vecs[i].rd; m_val = vecs[i].exp_val; m_valid = 1'b1;
         end
         chk_bypass($sformatf("vec%0d", i));
      end
      @(negedge clk_i);
      idle_inputs();

      // ---------------- late load completion ----------------
      run_delayed(3'd0, 32'hFFFF_FF80, "lb_late");
      run_delayed(3'd4, 32'h0000_0080, "lbu_late");

      // ---------------- done under external stall ----------------
      writes = 0;
      @(negedge clk_i);
      x_valid_i = 1'b1; x_load_i = 1'b1; x_fun_i = 3'd2; x_dm_addr_i = 32'h0000_4000;
      x_rd_i = 5'd21; x_rd_write_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk_i);
         w_stall_i      = (c < 4);
         dm_load_done_i = (c == 0);
         dm_data_l_i    = (c == 0) ? 32'h1357_2468 : $urandom();
         #4;
         chk($sformatf("held%0d_val", c), rf_rd_value_o, 32'h1357_2468);
         chk($sformatf("held%0d_stall", c), {31'd0, w_stall_req_o}, 32'd0);
         if (rf_rd_write_o) writes++;
      end
      chk("held_writes", writes, 32'd1);
      @(posedge clk_i); #1;
      m_rd = 5'd21; m_val = 32'h1357_2468; m_valid = 1'b1;
      chk_bypass("held");
      @(negedge clk_i);
      idle_inputs();

      // ---------------- store to x0, stray load strobe, then rd=0 ALU op ----------------
      writes = 0;
      @(negedge clk_i);
      x_valid_i = 1'b1; x_store_i = 1'b1; x_rd_i = 5'd0; x_rd_write_i = 1'b1;
      x_rd_value_i = 32'h7777_7777; x_dm_addr_i = 32'h0000_0100;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk_i);
         w_stall_i       = (c < 2);
         dm_store_done_i = (c == 2);
         dm_load_done_i  = (c == 1);
         #4;
         chk($sformatf("st%0d_stall", c), {31'd0, w_stall_req_o}, {31'd0, (c < 2)});
         chk($sformatf("st%0d_hazard", c), {31'd0, w_load_hazard_o}, 32'd0);
         if (rf_rd_write_o) writes++;
      end
      @(negedge clk_i);
      x_store_i = 1'b0; dm_store_done_i = 1'b0; dm_load_done_i = 1'b0; w_stall_i = 1'b0;
      x_rd_value_i = 32'h8888_8888;
      #4;
      if (rf_rd_write_o) writes++;
      chk("st_writes", writes, 32'd0);
      @(posedge clk_i); #1;
      chk_bypass("st");
      @(negedge clk_i);
      idle_inputs();

      // ---------------- asynchronous reset while waiting for memory ----------------
      @(negedge clk_i);
      x_valid_i = 1'b1; x_load_i = 1'b1; x_fun_i = 3'd2; x_rd_i = 5'd22; x_rd_write_i = 1'b1;
      w_stall_i = 1'b1;
      #4;
      chk("arst_pre_stall", {31'd0, w_stall_req_o}, 32'd1);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1; x_valid_i = 1'b0;
      #1;
      m_rd = 5'd0; m_val = 32'h0; m_valid = 1'b0;
      chk("arst_stall", {31'd0, w_stall_req_o}, 32'd0);
      chk("arst_we", {31'd0, rf_rd_write_o}, 32'd0);
      chk("arst_hazard", {31'd0, w_load_hazard_o}, 32'd0);
      chk_bypass("arst");
      @(negedge clk_i);
      rst_i = 1'b0; w_stall_i = 1'b0;
      @(negedge clk_i);
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hFEED_FACE;
      #4;
      chk("arst_late_we", {31'd0, rf_rd_write_o}, 32'd0);
      @(posedge clk_i); #1;
      chk_bypass("arst_late");
      @(negedge clk_i);
      idle_inputs();

      // ---------------- randomized instruction stream vs reference model ----------------
      m_mem_done = 1'b0; m_written = 1'b0; m_saved = 32'h0;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk_i);
            idle_inputs();
            x_load_i = 1'($urandom_range(0, 1)); dm_load_done_i = 1'($urandom_range(0, 1));
            w_stall_i = 1'($urandom_range(0, 1));
            #4;
            chk("bubble_we", {31'd0, rf_rd_write_o}, 32'd0);
            chk("bubble_stall", {31'd0, w_stall_req_o}, 32'd0);
            @(posedge clk_i); #1;
            chk_bypass("bubble");
         end
         r_kind  = 2'($urandom_range(0, 3));
         r_ld    = (r_kind == 2'd2);
         r_st    = (r_kind == 2'd3);
         r_wr    = 1'($urandom_range(0, 3) != 0);
         r_src   = 2'($urandom_range(0, 3));
         r_rd    = 5'($urandom_range(0, 31));
         r_fun   = 3'($urandom_range(0, 7));
         r_addr  = $urandom();
         r_alu   = $urandom();
         r_sh    = $urandom();
         r_mul   = $urandom();
         r_delay = $urandom_range(0, 3);
         r_retired = 1'b0;
         for (int c = 0; c < 16 && !r_retired; c++) begin
            @(negedge clk_i);
            x_valid_i = 1'b1; x_load_i = r_ld; x_store_i = r_st; x_rd_write_i = r_wr;
            x_rd_source_i = r_src; x_rd_i = r_rd; x_fun_i = r_fun; x_dm_addr_i = r_addr;
            x_rd_value_i = r_alu; x_shifter_rd_value_i = r_sh; x_multiply_rd_value_i = r_mul;
            dm_data_l_i = $urandom();
            dm_load_done_i  = r_ld ? ((c == r_delay) || (c > r_delay && $urandom_range(0, 1) == 1))
                                   : ($urandom_range(0, 3) == 0);
            dm_store_done_i = r_st ? ((c == r_delay) || (c > r_delay && $urandom_range(0, 1) == 1))
                                   : ($urandom_range(0, 3) == 0);
            e_done  = (r_ld & dm_load_done_i) | (r_st & dm_store_done_i);
            e_ok    = !(r_ld | r_st) || m_mem_done || e_done;
            e_stall = (r_ld | r_st) && !e_ok;
            e_we    = r_wr && (r_rd != 5'd0) && e_ok && !m_written;
            if (r_ld)
               e_val = m_mem_done ? m_saved : ref_align(r_fun, r_addr[1:0], dm_data_l_i);
            else
               e_val = (r_src == 2'd1) ? r_sh : (r_src == 2'd2) ? r_mul : r_alu;
            w_stall_i = e_stall ? 1'b1 : (c >= 12) ? 1'b0 : 1'($urandom_range(0, 2) == 0);
            #4;
            chk("rand_stall", {31'd0, w_stall_req_o}, {31'd0, e_stall});
            chk("rand_hazard", {31'd0, w_load_hazard_o}, {31'd0, r_ld & !e_ok});
            chk("rand_we", {31'd0, rf_rd_write_o}, {31'd0, e_we});
            if (e_we) begin
               chk("rand_val", rf_rd_value_o, e_val);
               chk("rand_rd", {27'd0, rf_rd_o}, {27'd0, r_rd});
            end
            @(posedge clk_i); #1;
            if (e_we) begin
               m_rd = r_rd; m_val = e_val; m_valid = 1'b1;
            end
            if (r_ld && e_done && !m_mem_done) m_saved = e_val;
            if (w_stall_i) begin
               if ((r_ld | r_st) && e_done) m_mem_done = 1'b1;
               if (e_we) m_written = 1'b1;
            end else begin
               m_mem_done = 1'b0;
               m_written  = 1'b0;
               r_retired  = 1'b1;
            end
            chk_bypass("rand");
         end
         chk("rand_retire", {31'd0, r_retired}, 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
